// File: rtl/isa_pkg.sv
// Shared 16-bit instruction format: field positions, widths and form/state enums.
// Used by the loader-side encoder and by the fetch/decode path.
package isa_pkg;

    localparam int INSTR_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam int OPC_W = OPC_MSB - OPC_LSB + 1;
    localparam int REG_W = RD_MSB - RD_LSB + 1;
    localparam int IMM_W = IMM_MSB - IMM_LSB + 1;

    typedef enum logic {
        FORM_R = 1'b0,
        FORM_I = 1'b1
    } form_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } enc_state_e;

    // Pack one field tuple into an instruction word.
    function automatic logic [INSTR_W-1:0] encode(
        input logic [OPC_W-1:0] opc,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2,
        input form_e            form,
        input logic [IMM_W-1:0] imm
    );
        logic [INSTR_W-1:0] w;
        w = '0;
        w[OPC_MSB:OPC_LSB] = opc;
        w[RD_MSB:RD_LSB]   = rd;
        w[RS1_MSB:RS1_LSB] = rs1;
        if (form == FORM_I) begin
            w[IMM_MSB:IMM_LSB] = imm;
        end else begin
            w[RS2_MSB:RS2_LSB] = rs2;
        end
        return w;
    endfunction

endpackage

// File: rtl/instruction_encoder_fifo.sv
// instr_fifo: DEPTH x W synchronous FIFO holding encoded instruction words.
// Ports: clk, reset, push/din, pop/dout, full, empty. Head word is read from storage.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic do_push;
    logic do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs field tuples into 16-bit instructions and streams them to program memory.
// Ports: start/in_* tuple handshake in, mem_* write handshake out, busy/done/err status.
module instruction_encoder
    import isa_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 8,
    parameter int PROG_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [1:0]        in_rd,
    input  logic [1:0]        in_rs1,
    input  logic [1:0]        in_rs2,
    input  logic              in_use_imm,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        err_count
);

    // Word counters need one extra bit so PROG_WORDS == 2**ADDR_W fits.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] PW_CNT  = CNT_W'(PROG_WORDS);
    localparam logic [CNT_W-1:0] PW_LAST = CNT_W'(PROG_WORDS - 1);

    enc_state_e state;
    enc_state_e state_n;

    logic [CNT_W-1:0]   acc_cnt;
    logic [CNT_W-1:0]   wr_cnt;
    logic [INSTR_W-1:0] word;
    logic [INSTR_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               cap_reached;
    logic               imm_bad;
    logic               take;
    logic               push;
    logic               reject;
    logic               pop;
    logic               open;
    form_e              form;

    assign form = in_use_imm ? FORM_I : FORM_R;
    assign word = encode(in_opcode, in_rd, in_rs1, in_rs2,
                         form, in_imm[IMM_W-1:0]);

    // Only I-form looks at the upper immediate bits.
    assign imm_bad     = in_use_imm & (|in_imm[15:8]);
    assign cap_reached = (acc_cnt == PW_CNT);
    assign in_ready    = (state == LOAD) & !fifo_full & !cap_reached;
    assign take        = in_valid & in_ready;
    assign push        = take & !imm_bad;
    assign reject      = take & imm_bad;

    assign mem_we    = !fifo_empty;
    assign mem_wdata = fifo_empty ? '0 : head;
    assign pop       = mem_we & mem_ready;

    assign open = start & (state != LOAD);
    assign busy = (state == LOAD);
    assign done = (state == DONE);

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (word),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) state_n = LOAD;
            end
            LOAD: begin
                if (pop && wr_cnt == PW_LAST) state_n = DONE;
            end
            DONE: begin
                if (start) state_n = LOAD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr <= '0;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
        end else if (open) begin
            mem_addr <= '0;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
        end else begin
            if (push) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
            if (pop) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                wr_cnt   <= wr_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err       <= 1'b0;
            err_count <= '0;
        end else if (reject) begin
            err <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
